alu_seq: RTL and testbench

Sequential 8-bit arithmetic/logic unit sitting directly upstream of the accumulator register. It combines the accumulator's current value (operand A) with an external operand (operand B) using one of eight operations. Multiplication is a multi-cycle shift-add operation. The result is committed to the accumulator through its increment-only `in`/`update` port. To do this, the block emits the delta `result - A` (mod 256) with a one-cycle update pulse, so the accumulator ends up holding exactly `result`.

---
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU feeding an increment-only accumulator.
// Commits result by emitting result - A as a one-cycle delta pulse.
module alu_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] operand,
    input  logic [7:0] acc_value,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic [7:0] acc_in,
    output logic       acc_update
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE
    } state_t;

    state_t      state;
    logic [2:0]  op_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] prod;
    logic [3:0]  count;

    logic [15:0] addend;
    logic [15:0] mul_next;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic        is_mul;
    logic        calc_done;

    // Operation result and the multiplier's next partial product.
    always_comb begin
        addend    = 16'h0000;
        if (b_r[count[2:0]])
            addend = {8'h00, a_r} << count[2:0];
        mul_next  = prod + addend;
        sum       = {1'b0, a_r} + {1'b0, b_r};
        diff      = {1'b0, a_r} - {1'b0, b_r};
        is_mul    = (op_r == 3'b111);
        calc_done = !is_mul || (count == 4'd7);
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        unique case (op_r)
            3'b000: begin
                alu_res   = sum[7:0];
                alu_carry = sum[8];
            end
            3'b001: begin
                alu_res   = diff[7:0];
                alu_carry = diff[8];
            end
            3'b010: alu_res = a_r & b_r;
            3'b011: alu_res = a_r | b_r;
            3'b100: alu_res = a_r ^ b_r;
            3'b101: begin
                alu_res   = {a_r[6:0], 1'b0};
                alu_carry = a_r[7];
            end
            3'b110: begin
                alu_res   = {1'b0, a_r[7:1]};
                alu_carry = a_r[0];
            end
            3'b111: begin
                alu_res   = mul_next[7:0];
                alu_carry = |mul_next[15:8];
            end
        endcase
    end

    // Control FSM with registered flags, result and accumulator delta.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_r       <= 3'b000;
            a_r        <= 8'h00;
            b_r        <= 8'h00;
            prod       <= 16'h0000;
            count      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 8'h00;
            carry      <= 1'b0;
            zero       <= 1'b1;
            acc_in     <= 8'h00;
            acc_update <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done       <= 1'b0;
                    acc_update <= 1'b0;
                    acc_in     <= 8'h00;
                    if (start) begin
                        op_r  <= op;
                        a_r   <= acc_value;
                        b_r   <= operand;
                        prod  <= 16'h0000;
                        count <= 4'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (is_mul) begin
                        prod  <= mul_next;
                        count <= count + 4'd1;
                    end
                    if (calc_done) begin
                        result     <= alu_res;
                        carry      <= alu_carry;
                        zero       <= (alu_res == 8'h00);
                        acc_in     <= alu_res - a_r;
                        acc_update <= 1'b1;
                        done       <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    acc_update <= 1'b0;
                    done       <= 1'b0;
                    acc_in     <= 8'h00;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural accumulator
// driven by the acc_in/acc_update pulse.
module tb_alu_seq;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] operand;
    logic [7:0] acc_value;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] acc_in;
    logic       acc_update;

    logic       acc_rst;
    logic [7:0] acc;

    int passed = 0;
    int total  = 0;

    alu_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .acc_value (acc_value),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .acc_in    (acc_in),
        .acc_update(acc_update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Increment-only accumulator downstream of the ALU.
    always @(posedge clock or posedge acc_rst) begin
        if (acc_rst)
            acc <= 8'h00;
        else if (acc_update)
            acc <= acc + acc_in;
    end

    assign acc_value = acc;

    // Launch one op and observe it until busy drops (bounded).
    task automatic run_op(
        input  logic [2:0] o,
        input  logic [7:0] b,
        output int         cyc,
        output int         upd,
        output int         dn,
        output logic [7:0] r,
        output logic       c,
        output logic       z,
        output logic [7:0] d,
        output bit         to
    );
        cyc = 0; upd = 0; dn = 0;
        r = 8'h00; c = 1'b0; z = 1'b0; d = 8'h00;
        to = 1'b1;
        @(negedge clock);
        start = 1'b1; op = o; operand = b;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            cyc++;
            if (acc_update) begin
                upd++;
                d = acc_in; r = result; c = carry; z = zero;
            end
            if (done) dn++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
        total++; if (result !== 8'h00) $display("FAIL rst_result got %h want 00", result); else passed++;
        total++; if (carry !== 1'b0) $display("FAIL rst_carry got %b want 0", carry); else passed++;
        total++; if (zero !== 1'b1) $display("FAIL rst_zero got %b want 1", zero); else passed++;
        total++; if (acc_in !== 8'h00) $display("FAIL rst_acc_in got %h want 00", acc_in); else passed++;
        total++; if (acc_update !== 1'b0) $display("FAIL rst_update got %b want 0", acc_update); else passed++;
    endtask

    task automatic test_add();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        run_op(3'b000, 8'h05, cyc, upd, dn, r, c, z, d, to);
        total++; if (to !== 1'b0) $display("FAIL add_timeout got %b want 0", to); else passed++;
        total++; if (cyc != 2) $display("FAIL add_busy_cycles got %0d want 2", cyc); else passed++;
        total++; if (upd != 1) $display("FAIL add_updates got %0d want 1", upd); else passed++;
        total++; if (dn != 1) $display("FAIL add_done got %0d want 1", dn); else passed++;
        total++; if (d !== 8'h05) $display("FAIL add_acc_in got %h want 05", d); else passed++;
        total++; if (r !== 8'h05) $display("FAIL add_result got %h want 05", r); else passed++;
        total++; if (c !== 1'b0 || z !== 1'b0) $display("FAIL add_flags got c%b z%b want c0 z0", c, z); else passed++;
        total++; if (acc !== 8'h05) $display("FAIL add_acc got %h want 05", acc); else passed++;
    endtask

    task automatic test_sub();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        run_op(3'b001, 8'h07, cyc, upd, dn, r, c, z, d, to);
        total++; if (to !== 1'b0) $display("FAIL sub_timeout got %b want 0", to); else passed++;
        total++; if (r !== 8'hFE) $display("FAIL sub_result got %h want fe", r); else passed++;
        total++; if (c !== 1'b1) $display("FAIL sub_borrow got %b want 1", c); else passed++;
        total++; if (d !== 8'hF9) $display("FAIL sub_acc_in got %h want f9", d); else passed++;
        total++; if (acc !== 8'hFE) $display("FAIL sub_acc got %h want fe", acc); else passed++;
    endtask

    task automatic test_mul();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        // 0xFE + 0x07 wraps to 0x05 with carry
        run_op(3'b000, 8'h07, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h05 || c !== 1'b1) $display("FAIL add_wrap got %h c%b want 05 c1", r, c); else passed++;
        run_op(3'b111, 8'h07, cyc, upd, dn, r, c, z, d, to);
        total++; if (to !== 1'b0) $display("FAIL mul_timeout got %b want 0", to); else passed++;
        total++; if (cyc != 9) $display("FAIL mul_busy_cycles got %0d want 9", cyc); else passed++;
        total++; if (r !== 8'h23) $display("FAIL mul_result got %h want 23", r); else passed++;
        total++; if (d !== 8'h1E) $display("FAIL mul_acc_in got %h want 1e", d); else passed++;
        total++; if (c !== 1'b0) $display("FAIL mul_carry got %b want 0", c); else passed++;
        total++; if (acc !== 8'h23) $display("FAIL mul_acc got %h want 23", acc); else passed++;
        run_op(3'b100, 8'h33, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h10 || c !== 1'b0) $display("FAIL xor_result got %h c%b want 10 c0", r, c); else passed++;
        run_op(3'b111, 8'h20, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h00) $display("FAIL mul_ovf_result got %h want 00", r); else passed++;
        total++; if (z !== 1'b1 || c !== 1'b1) $display("FAIL mul_ovf_flags got z%b c%b want z1 c1", z, c); else passed++;
        total++; if (d !== 8'hF0) $display("FAIL mul_ovf_acc_in got %h want f0", d); else passed++;
        total++; if (acc !== 8'h00) $display("FAIL mul_ovf_acc got %h want 00", acc); else passed++;
    endtask

    task automatic test_shift();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        run_op(3'b011, 8'h81, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h81) $display("FAIL or_result got %h want 81", r); else passed++;
        run_op(3'b101, 8'h00, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h02 || c !== 1'b1) $display("FAIL shl got %h c%b want 02 c1", r, c); else passed++;
        run_op(3'b100, 8'h83, cyc, upd, dn, r, c, z, d, to);
        total++; if (acc !== 8'h81) $display("FAIL xor_acc got %h want 81", acc); else passed++;
        run_op(3'b110, 8'h00, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h40 || c !== 1'b1) $display("FAIL shr got %h c%b want 40 c1", r, c); else passed++;
        total++; if (d !== 8'hBF) $display("FAIL shr_acc_in got %h want bf", d); else passed++;
    endtask

    task automatic test_wrap();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        run_op(3'b011, 8'hFF, cyc, upd, dn, r, c, z, d, to);
        run_op(3'b000, 8'h01, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) $display("FAIL add_ff got %h c%b z%b want 00 c1 z1", r, c, z); else passed++;
        total++; if (d !== 8'h01) $display("FAIL add_ff_acc_in got %h want 01", d); else passed++;
        run_op(3'b011, 8'hFE, cyc, upd, dn, r, c, z, d, to);
        run_op(3'b000, 8'h04, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h02 || d !== 8'h04) $display("FAIL delta_wrap got %h/%h want 02/04", r, d); else passed++;
        run_op(3'b010, 8'h03, cyc, upd, dn, r, c, z, d, to);
        total++; if (r !== 8'h02 || c !== 1'b0 || d !== 8'h00) $display("FAIL and got %h c%b d%h want 02 c0 d00", r, c, d); else passed++;
        total++; if (acc !== 8'h02) $display("FAIL and_acc got %h want 02", acc); else passed++;
    endtask

    task automatic test_ignore();
        int upd = 0;
        int dn = 0;
        logic [7:0] r = 8'h00;
        logic [7:0] d = 8'h00;
        @(negedge clock);
        start = 1'b1; op = 3'b111; operand = 8'h03;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin
                start = 1'b1; op = 3'b000; operand = 8'h55;
            end
            if (k == 4) start = 1'b0;
            if (acc_update) begin
                upd++; r = result; d = acc_in;
            end
            if (done) dn++;
            @(negedge clock);
        end
        total++; if (dn != 1) $display("FAIL ign_done got %0d want 1", dn); else passed++;
        total++; if (upd != 1) $display("FAIL ign_updates got %0d want 1", upd); else passed++;
        total++; if (r !== 8'h06 || d !== 8'h04) $display("FAIL ign_result got %h/%h want 06/04", r, d); else passed++;
        total++; if (acc !== 8'h06 || busy !== 1'b0) $display("FAIL ign_final got acc %h busy %b want 06 0", acc, busy); else passed++;
    endtask

    task automatic test_abort();
        int cyc, upd, dn; logic [7:0] r, d; logic c, z; bit to;
        int late_upd = 0;
        @(negedge clock);
        start = 1'b1; op = 3'b111; operand = 8'h09;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (busy !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", busy); else passed++;
        reset = 1'b1;
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (acc_update || done || busy) late_upd++;
            @(negedge clock);
        end
        total++; if (late_upd != 0) $display("FAIL abort_activity got %0d want 0", late_upd); else passed++;
        total++; if (acc !== 8'h06) $display("FAIL abort_acc got %h want 06", acc); else passed++;
        run_op(3'b000, 8'h0A, cyc, upd, dn, r, c, z, d, to);
        total++; if (to !== 1'b0 || cyc != 2) $display("FAIL post_abort_timing got to%b cyc%0d want 0/2", to, cyc); else passed++;
        total++; if (r !== 8'h10 || acc !== 8'h10) $display("FAIL post_abort got %h acc %h want 10", r, acc); else passed++;
    endtask

    task automatic test_back_to_back();
        int dn = 0;
        logic [7:0] r = 8'h00;
        @(negedge clock);
        start = 1'b1; op = 3'b000; operand = 8'h01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 3) start = 1'b0;
            if (done) begin
                dn++; r = result;
            end
        end
        total++; if (dn != 2) $display("FAIL b2b_done got %0d want 2", dn); else passed++;
        total++; if (r !== 8'h12) $display("FAIL b2b_result got %h want 12", r); else passed++;
        total++; if (acc !== 8'h12) $display("FAIL b2b_acc got %h want 12", acc); else passed++;
    endtask

    initial begin
        reset = 1'b1; acc_rst = 1'b1;
        start = 1'b0; op = 3'b000; operand = 8'h00;
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0; acc_rst = 1'b0;
        @(negedge clock);
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_wrap();
        test_ignore();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
